// File: rtl/quick_spi_slave.sv
// SPI mode-0 slave with all pins oversampled in the clk domain.
// Exchanges DATA_WIDTH-bit words MSB first through a one-word tx buffer and an rx holding register.
module quick_spi_slave #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic sclk_s1, sclk_s2, sclk_s3;
    logic ss_s1, ss_s2, ss_s3;
    logic mosi_s1, mosi_s2;

    logic [CW-1:0]         bit_cnt_q;
    logic                  boundary_q;
    logic [DATA_WIDTH-1:0] rx_shift_q;
    logic [DATA_WIDTH-1:0] tx_shift_q;
    logic [DATA_WIDTH-1:0] tx_buf_q;
    logic                  buf_full_q;

    logic sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic word_start, rise_act, fall_act, consume, word_done;
    logic [DATA_WIDTH-1:0] rx_next;

    // Synchronizers; the select chain idles high so no spurious frame start follows reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_s3   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            ss_s1   <= ss_n;
            ss_s2   <= ss_s1;
            ss_s3   <= ss_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign ss_fall   = ~ss_s2 & ss_s3;
    assign ss_rise   = ss_s2 & ~ss_s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall) state_d = ACTIVE;
            ACTIVE:  if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A deselect in the same cycle as an sclk edge suppresses that edge.
    assign word_start = (state_q == IDLE) && ss_fall;
    assign rise_act   = (state_q == ACTIVE) && !ss_rise && sclk_rise;
    assign fall_act   = (state_q == ACTIVE) && !ss_rise && sclk_fall;
    assign consume    = word_start || (fall_act && boundary_q);
    assign word_done  = rise_act && (bit_cnt_q == LAST_BIT);
    assign rx_next    = {rx_shift_q[DATA_WIDTH-2:0], mosi_s2};

    assign busy     = (state_q == ACTIVE);
    assign miso_oe  = busy;
    assign miso     = busy & tx_shift_q[DATA_WIDTH-1];
    assign tx_ready = ~buf_full_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q   <= '0;
            boundary_q  <= 1'b0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            tx_buf_q    <= '0;
            buf_full_q  <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            if (word_start || ((state_q == ACTIVE) && ss_rise)) begin
                bit_cnt_q  <= '0;
                boundary_q <= 1'b0;
                rx_shift_q <= '0;
            end else if (rise_act) begin
                rx_shift_q <= rx_next;
                if (word_done) begin
                    rx_data    <= rx_next;
                    rx_valid   <= 1'b1;
                    bit_cnt_q  <= '0;
                    boundary_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end else if (fall_act && boundary_q) begin
                boundary_q <= 1'b0;
            end

            // An empty buffer at a word start sends zeros and flags the underrun.
            if (consume) begin
                if (buf_full_q) begin
                    tx_shift_q <= tx_buf_q;
                    buf_full_q <= 1'b0;
                end else begin
                    tx_shift_q  <= '0;
                    tx_underrun <= 1'b1;
                end
            end else if (fall_act) begin
                tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end

            if (tx_load && !buf_full_q && !consume) begin
                tx_buf_q   <= tx_data;
                buf_full_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_quick_spi_slave.sv
// Bench for quick_spi_slave: a bit-level SPI master plus a word-level model of the
// tx buffer, expected miso words, received words and underrun pulses.
module tb_quick_spi_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk, ss_n, mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, tx_underrun, busy;

    quick_spi_slave #(.DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: one-word tx buffer plus expected rx words and underrun count.
    logic       model_full = 1'b0;
    logic [7:0] model_buf  = '0;
    logic [7:0] exp_q[$];
    int         exp_und = 0;

    // Observed results.
    logic [7:0] got_rx[$];
    int         und_cnt = 0;

    // Frame description shared between the stimulus code and run_frame.
    logic [7:0] fr_mosi  [0:3];
    logic       fr_rl_en [0:3];
    logic [7:0] fr_rl    [0:3];
    logic [7:0] fr_got   [0:3];

    typedef struct {
        logic       pre_en;
        logic [7:0] pre;
        logic [7:0] mosi_word;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_und;
    } vec_t;

    vec_t tab [0:3];

    always @(negedge clk) begin
        if (rx_valid) got_rx.push_back(rx_data);
        if (tx_underrun) und_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A load is accepted only when the modelled buffer is empty.
    task automatic do_load(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
        if (!model_full) begin
            model_full = 1'b1;
            model_buf  = d;
        end
    endtask

    function automatic logic [7:0] take();
        if (model_full) begin
            model_full = 1'b0;
            return model_buf;
        end
        exp_und++;
        return 8'h00;
    endfunction

    // One ss_n frame of nw words; abort_bits >= 0 deselects after that many sclk pulses.
    task automatic run_frame(input int nw, input int abort_bits);
        int h;
        int nbits;
        logic stop;
        logic [7:0] exp_m [0:3];
        logic [7:0] got;
        logic [7:0] nx;
        h     = $urandom_range(4, 7);
        nbits = 0;
        stop  = 1'b0;
        got_rx.delete();
        exp_q.delete();
        und_cnt = 0;
        exp_und = 0;
        ss_n     = 1'b0;
        exp_m[0] = take();
        wait_clk(h);
        for (int w = 0; w < nw; w++) begin
            got = '0;
            for (int b = 7; b >= 0; b--) begin
                if (abort_bits >= 0 && nbits == abort_bits) begin
                    stop = 1'b1;
                    break;
                end
                mosi = fr_mosi[w][b];
                wait_clk(h);
                got[b] = miso;
                if (w == 0 && b == 7) begin
                    check("busy_active", {31'b0, busy}, 32'd1);
                    check("miso_oe_active", {31'b0, miso_oe}, 32'd1);
                    check("tx_ready_at_start", {31'b0, tx_ready}, {31'b0, !model_full});
                end
                sclk = 1'b1;
                if (b == 7 && fr_rl_en[w]) begin
                    wait_clk(2);
                    check("tx_ready_before_reload", {31'b0, tx_ready}, 32'd1);
                    do_load(fr_rl[w]);
                    wait_clk(h - 3);
                end else begin
                    wait_clk(h);
                end
                sclk = 1'b0;
                nbits++;
            end
            if (stop) break;
            fr_got[w] = got;
            check("miso_word", {24'b0, got}, {24'b0, exp_m[w]});
            exp_q.push_back(fr_mosi[w]);
            nx = take();
            if (w + 1 < nw) exp_m[w+1] = nx;
        end
        wait_clk(h);
        ss_n = 1'b1;
        mosi = 1'b0;
        wait_clk(8);
        check("rx_count", got_rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_rx.size(); i++)
            check("rx_word", {24'b0, got_rx[i]}, {24'b0, exp_q[i]});
        check("underrun_count", und_cnt, exp_und);
        check("busy_idle", {31'b0, busy}, 32'd0);
        check("miso_oe_idle", {31'b0, miso_oe}, 32'd0);
        check("miso_idle", {31'b0, miso}, 32'd0);
        check("tx_ready_idle", {31'b0, tx_ready}, {31'b0, !model_full});
    endtask

    initial begin
        tab[0] = '{1'b1, 8'hA5, 8'h5A, 8'hA5, 8'h5A, 1};
        tab[1] = '{1'b0, 8'h00, 8'h81, 8'h00, 8'h81, 2};
        tab[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 1};
        tab[3] = '{1'b1, 8'h01, 8'h80, 8'h01, 8'h80, 1};
        for (int i = 0; i < 4; i++) begin
            fr_rl_en[i] = 1'b0;
            fr_rl[i]    = '0;
            fr_mosi[i]  = '0;
        end

        reset = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_load = 1'b0;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(2);
        check("reset_miso", {31'b0, miso}, 32'd0);
        check("reset_miso_oe", {31'b0, miso_oe}, 32'd0);
        check("reset_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("reset_rx_data", {24'b0, rx_data}, 32'd0);
        check("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("reset_tx_underrun", {31'b0, tx_underrun}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            fr_mosi[0] = tab[i].mosi_word;
            if (tab[i].pre_en) do_load(tab[i].pre);
            run_frame(1, -1);
            check("tab_miso", {24'b0, fr_got[0]}, {24'b0, tab[i].exp_miso});
            check("tab_rx_data", {24'b0, rx_data}, {24'b0, tab[i].exp_rx});
            check("tab_underruns", und_cnt, tab[i].exp_und);
        end

        // Back-to-back words with a reload between them.
        do_load(8'h3C);
        fr_mosi[0] = 8'h01; fr_mosi[1] = 8'hFF;
        fr_rl_en[0] = 1'b1; fr_rl[0] = 8'hC3;
        run_frame(2, -1);
        fr_rl_en[0] = 1'b0;
        check("b2b_miso0", {24'b0, fr_got[0]}, 32'h3C);
        check("b2b_miso1", {24'b0, fr_got[1]}, 32'hC3);
        check("b2b_rx_count", got_rx.size(), 2);

        // Abort after 5 bits, then a clean frame.
        do_load(8'h96);
        fr_mosi[0] = 8'hE7;
        run_frame(1, 5);
        check("abort_no_rx", got_rx.size(), 0);
        do_load(8'h69);
        fr_mosi[0] = 8'h2B;
        run_frame(1, -1);
        check("after_abort_rx", {24'b0, rx_data}, 32'h2B);
        check("after_abort_miso", {24'b0, fr_got[0]}, 32'h69);

        // Ignored load while full, and sclk toggling while deselected.
        do_load(8'h11);
        check("full_tx_ready", {31'b0, tx_ready}, 32'd0);
        do_load(8'h22);
        got_rx.delete();
        repeat (10) begin
            sclk = 1'b1; mosi = ~mosi; wait_clk(5);
            sclk = 1'b0; wait_clk(5);
        end
        check("idle_sclk_no_rx", got_rx.size(), 0);
        check("idle_sclk_busy", {31'b0, busy}, 32'd0);
        fr_mosi[0] = 8'h44;
        run_frame(1, -1);
        check("ignored_load_miso", {24'b0, fr_got[0]}, 32'h11);

        // Reset during bit 4 of a frame.
        do_load(8'h77);
        void'(take());
        got_rx.delete();
        ss_n = 1'b0;
        wait_clk(5);
        for (int b = 7; b >= 4; b--) begin
            mosi = b[0];
            wait_clk(5);
            sclk = 1'b1;
            if (b == 4) begin
                wait_clk(2);
                reset = 1'b1;
                wait_clk(1);
                check("rst_mid_miso", {31'b0, miso}, 32'd0);
                check("rst_mid_miso_oe", {31'b0, miso_oe}, 32'd0);
                check("rst_mid_busy", {31'b0, busy}, 32'd0);
                check("rst_mid_tx_ready", {31'b0, tx_ready}, 32'd1);
                check("rst_mid_rx_data", {24'b0, rx_data}, 32'd0);
                check("rst_mid_rx_valid", {31'b0, rx_valid}, 32'd0);
                check("rst_mid_underrun", {31'b0, tx_underrun}, 32'd0);
            end else begin
                wait_clk(5);
            end
            sclk = 1'b0;
        end
        ss_n = 1'b1; mosi = 1'b0;
        wait_clk(2);
        reset = 1'b0;
        model_full = 1'b0;
        wait_clk(8);
        check("rst_mid_no_rx", got_rx.size(), 0);
        do_load(8'hB4);
        fr_mosi[0] = 8'hD2;
        run_frame(1, -1);
        check("after_reset_rx", {24'b0, rx_data}, 32'hD2);

        // Randomized frames against the model.
        for (int f = 0; f < 20; f++) begin
            int nw;
            nw = $urandom_range(1, 3);
            for (int w = 0; w < 4; w++) begin
                fr_mosi[w]  = 8'($urandom);
                fr_rl[w]    = 8'($urandom);
                fr_rl_en[w] = (w < nw) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (!model_full && $urandom_range(0, 3) != 0) do_load(8'($urandom));
            run_frame(nw, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8 * nw - 1)) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
